uart_debug_cmd_decoder: RTL

UART_DEBUG_CMD_DECODER -- requirements
Module: uart_debug_cmd_decoder

---
 rtl/debug_bus_pkg.sv | 26 ++
 rtl/uart_debug_cmd_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/debug_bus_pkg.sv
// Shared constants for the UART debug command path: opcodes, response
// opcodes, status codes and decoder FSM state encodings.
package debug_bus_pkg;

  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;

  localparam logic [7:0] RSP_FLAG    = 8'h80;
  localparam logic [7:0] RSP_UNKNOWN = 8'hFF;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BUS_ERR  = 8'h01;
  localparam logic [7:0] ST_TIMEOUT  = 8'h02;
  localparam logic [7:0] ST_BAD_OP   = 8'hE0;
  localparam logic [7:0] ST_BAD_LEN  = 8'hE1;

  localparam logic [1:0] S_RECV  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_BUS   = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/uart_debug_cmd_decoder.sv
// Decodes WRITE/READ command packets arriving as AXIS bytes, runs one
// register-bus transaction and streams back an opcode/status(/data) response.
module uart_debug_cmd_decoder
  import debug_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_s_axis_tvalid,
  output logic                  o_s_axis_tready,
  input  logic [7:0]            i_s_axis_tdata,
  input  logic                  i_s_axis_tlast,
  input  logic                  i_s_axis_tkeep,
  output logic                  o_m_axis_tvalid,
  input  logic                  i_m_axis_tready,
  output logic [7:0]            o_m_axis_tdata,
  output logic                  o_m_axis_tlast,
  output logic                  o_m_axis_tkeep,
  output logic                  o_reg_req,
  output logic                  o_reg_we,
  output logic [ADDR_WIDTH-1:0] o_reg_addr,
  output logic [DATA_WIDTH-1:0] o_reg_wdata,
  input  logic                  i_reg_ack,
  input  logic                  i_reg_err,
  input  logic [DATA_WIDTH-1:0] i_reg_rdata
);

  localparam int AB  = (ADDR_WIDTH + 7) / 8;
  localparam int DB  = DATA_WIDTH / 8;
  localparam int AW8 = AB * 8;
  localparam int CW  = $clog2(1 + AB + DB + 2);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW  = $clog2(DB + 3);

  localparam logic [CW-1:0] WR_LEN = CW'(1 + AB + DB);
  localparam logic [CW-1:0] RD_LEN = CW'(1 + AB);
  localparam logic [CW-1:0] AB_C   = CW'(AB);

  logic [1:0]            r_state;
  logic                  r_rdy;
  logic [CW-1:0]         r_cnt;
  logic [7:0]            r_op;
  logic [AW8-1:0]        r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_req;
  logic                  r_we;
  logic [TW-1:0]         r_tmr;
  logic [7:0]            r_rsp_op;
  logic [7:0]            r_status;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [RW-1:0]         r_idx;
  logic [RW-1:0]         r_rlen;

  logic          w_s_fire;
  logic          w_kept;
  logic [CW-1:0] w_cnt_nxt;
  logic [7:0]    w_op;
  logic          w_known;
  logic [CW-1:0] w_exp_len;
  logic [7:0]    w_err_rsp;
  logic [7:0]    w_err_st;
  logic          w_m_valid;
  logic          w_m_last;
  logic [7:0]    w_rsp_byte;

  // r_rdy keeps tready low until the first edge after reset release
  assign o_s_axis_tready = r_rdy && (r_state == S_RECV || r_state == S_DRAIN);
  assign w_s_fire  = i_s_axis_tvalid && o_s_axis_tready;
  assign w_kept    = w_s_fire && i_s_axis_tkeep;
  assign w_cnt_nxt = r_cnt + (w_kept ? CW'(1) : CW'(0));
  // Opcode as seen including the current beat (first kept byte)
  assign w_op      = (r_cnt == '0 && w_kept) ? i_s_axis_tdata : r_op;
  assign w_known   = op_known(w_op);
  assign w_exp_len = (w_op == OP_WRITE) ? WR_LEN : RD_LEN;
  assign w_err_rsp = w_known ? (w_op | RSP_FLAG) : RSP_UNKNOWN;
  assign w_err_st  = w_known ? ST_BAD_LEN : ST_BAD_OP;

  assign w_m_valid = (r_state == S_RESP);
  assign w_m_last  = w_m_valid && (r_idx == r_rlen - 1'b1);

  assign o_m_axis_tvalid = w_m_valid;
  assign o_m_axis_tlast  = w_m_last;
  assign o_m_axis_tdata  = w_m_valid ? w_rsp_byte : 8'h00;
  assign o_m_axis_tkeep  = 1'b1;
  assign o_reg_req       = r_req;
  assign o_reg_we        = r_we;
  assign o_reg_addr      = r_addr[ADDR_WIDTH-1:0];
  assign o_reg_wdata     = r_wdata;

  // Response byte select: opcode, status, then read data MSB-first
  always_comb begin
    w_rsp_byte = 8'h00;
    if (r_idx == RW'(0))      w_rsp_byte = r_rsp_op;
    else if (r_idx == RW'(1)) w_rsp_byte = r_status;
    else begin
      for (int k = 0; k < DB; k++)
        if (r_idx == RW'(k + 2)) w_rsp_byte = r_rdata[DATA_WIDTH-1-8*k -: 8];
    end
  end

  // Command parse, bus handshake and response sequencing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_RECV;
      r_rdy    <= 1'b0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_tmr    <= '0;
      r_rsp_op <= '0;
      r_status <= '0;
      r_rdata  <= '0;
      r_idx    <= '0;
      r_rlen   <= '0;
    end else begin
      r_rdy <= 1'b1;
      case (r_state)
        S_RECV: if (w_s_fire) begin
          if (i_s_axis_tkeep) begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == '0)        r_op    <= i_s_axis_tdata;
            else if (r_cnt <= AB_C) r_addr  <= AW8'({r_addr, i_s_axis_tdata});
            else                    r_wdata <= DATA_WIDTH'({r_wdata, i_s_axis_tdata});
          end
          if (i_s_axis_tlast) begin
            if (w_known && w_cnt_nxt == w_exp_len) begin
              r_state <= S_BUS;
              r_req   <= 1'b1;
              r_we    <= (w_op == OP_WRITE);
              r_tmr   <= '0;
            end else begin
              r_state  <= S_RESP;
              r_rsp_op <= w_err_rsp;
              r_status <= w_err_st;
              r_rlen   <= RW'(2);
              r_idx    <= '0;
            end
          end else if ((w_kept && !w_known) || (w_cnt_nxt > w_exp_len)) begin
            // Bad opcode or overrun: swallow the rest of the packet first
            r_state  <= S_DRAIN;
            r_rsp_op <= w_err_rsp;
            r_status <= w_err_st;
          end
        end
        S_DRAIN: if (w_s_fire && i_s_axis_tlast) begin
          r_state <= S_RESP;
          r_rlen  <= RW'(2);
          r_idx   <= '0;
        end
        S_BUS: begin
          r_rsp_op <= r_op | RSP_FLAG;
          r_idx    <= '0;
          if (i_reg_ack) begin
            r_req    <= 1'b0;
            r_rdata  <= i_reg_rdata;
            r_status <= i_reg_err ? ST_BUS_ERR : ST_OK;
            r_rlen   <= (!r_we && !i_reg_err) ? RW'(2 + DB) : RW'(2);
            r_state  <= S_RESP;
          end else if (r_tmr == TW'(TIMEOUT_CYCLES - 1)) begin
            r_req    <= 1'b0;
            r_status <= ST_TIMEOUT;
            r_rlen   <= RW'(2);
            r_state  <= S_RESP;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: if (i_m_axis_tready) begin
          if (w_m_last) begin
            r_state <= S_RECV;
            r_cnt   <= '0;
            r_op    <= '0;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
